// File: rtl/sa_tile_scheduler_pkg.sv
// Shared definitions for the tile scheduler: tile edge, widths taken from
// Macro.svh, the scheduler state enum and a dimension legality helper.
// No ports (package).
`include "Macro.svh"

package sa_tile_scheduler_pkg;

    localparam int TILE   = 8;
    localparam int BEATS  = TILE * TILE;
    localparam int DATA_W = `DATA_WIDTH;
    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DIM_W  = `DIM_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_SA = 3'd3,
        CAPTURE = 3'd4,
        WRITE   = 3'd5,
        ADVANCE = 3'd6,
        FINISH  = 3'd7
    } sched_state_t;

    // A dimension is usable only when it is a non-zero multiple of the tile edge.
    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d[2:0] == 3'd0);
    endfunction

endpackage

// File: rtl/Macro.svh
// Shared width macros for the systolic-array datapath.
//   DATA_WIDTH : width of one matrix element / accumulator word
//   ADDR_WIDTH : element address width (all address math wraps at this width)
//   DIM_WIDTH  : width of a matrix dimension in elements
`ifndef SA_MACRO_SVH
`define SA_MACRO_SVH
`define DATA_WIDTH 32
`define ADDR_WIDTH 32
`define DIM_WIDTH  16
`endif

// File: rtl/sa_tile_wb.sv
// Tile write-back unit: holds the 8x8 result tile captured from the systolic
// driver and streams it out as 64 C write beats, row-major (row outer).
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   capture            : copy sa_out into the tile buffer this edge, rewind beat
//   write_en           : scheduler is in WRITE; beats are offered while high
//   sa_out             : driver result tile [row][col]
//   row_base           : address of tile element (0,0) in C
//   stride             : C row stride in elements (N)
//   accum              : beats of this tile add into existing C words
//   wr_ready           : sink acceptance
//   wr_valid/addr/data/accum : current beat, all zero while not writing
//   last_beat          : beat 63 transfers this cycle
//
// Handshake: a beat transfers on a rising edge where wr_valid && wr_ready.
// wr_valid, wr_addr and wr_data are functions of the beat counter, which only
// moves on a transfer, so they hold while wr_ready is low.
`include "Macro.svh"

module sa_tile_wb
    import sa_tile_scheduler_pkg::*;
(
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 capture,
    input  logic                                 write_en,
    input  logic [TILE-1:0][TILE-1:0][DATA_W-1:0] sa_out,
    input  logic [ADDR_W-1:0]                    row_base,
    input  logic [DIM_W-1:0]                     stride,
    input  logic                                 accum,
    input  logic                                 wr_ready,
    output logic                                 wr_valid,
    output logic [ADDR_W-1:0]                    wr_addr,
    output logic [DATA_W-1:0]                    wr_data,
    output logic                                 wr_accum,
    output logic                                 last_beat
);

    logic [TILE-1:0][TILE-1:0][DATA_W-1:0] tile_buf;
    logic [5:0]                            beat_q;
    logic [2:0]                            row;
    logic [2:0]                            col;

    assign row = beat_q[5:3];
    assign col = beat_q[2:0];

    // Data storage only; its contents are meaningless until the next capture,
    // so it carries no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            tile_buf <= sa_out;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else if (capture) begin
            beat_q <= '0;
        end else if (write_en && wr_ready) begin
            beat_q <= beat_q + 6'd1;
        end
    end

    // Outputs are gated by write_en so the bus reads zero outside WRITE,
    // including right after reset when tile_buf is unknown.
    assign wr_valid  = write_en;
    assign wr_addr   = write_en ? (row_base + ADDR_W'(row) * ADDR_W'(stride) + ADDR_W'(col)) : '0;
    assign wr_data   = write_en ? tile_buf[row][col] : '0;
    assign wr_accum  = write_en & accum;
    assign last_beat = write_en && wr_ready && (beat_q == 6'(BEATS - 1));

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile scheduler for C = A x B on an 8x8 systolic array driver. Walks the
// output in 8x8 tiles (ti rows, tj cols) and, per output tile, every K slice
// tk (innermost). Each slice launches the driver, captures its tile and
// writes it to C; slices with tk != 0 accumulate into C.
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   go                             : job start, sampled only in IDLE
//   base_A/B/C, dim_M/K/N          : job description, latched on go
//   sa_start                       : one-cycle driver launch
//   sa_base_A/B, sa_dim_col_A/B    : driver tile bases and row strides
//   sa_done, sa_out                : driver completion and result tile
//   wr_valid/addr/data/accum, wr_ready : C write beat stream
//   busy, done, err                : status; done/err are single pulses
//   dbg_state                      : current FSM state
`include "Macro.svh"

module sa_tile_scheduler
    import sa_tile_scheduler_pkg::*;
#(
    parameter int TILE = 8
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               go,
    input  logic [`ADDR_WIDTH-1:0]             base_A,
    input  logic [`ADDR_WIDTH-1:0]             base_B,
    input  logic [`ADDR_WIDTH-1:0]             base_C,
    input  logic [`DIM_WIDTH-1:0]              dim_M,
    input  logic [`DIM_WIDTH-1:0]              dim_K,
    input  logic [`DIM_WIDTH-1:0]              dim_N,
    output logic                               sa_start,
    output logic [`ADDR_WIDTH-1:0]             sa_base_A,
    output logic [`ADDR_WIDTH-1:0]             sa_base_B,
    output logic [`DIM_WIDTH-1:0]              sa_dim_col_A,
    output logic [`DIM_WIDTH-1:0]              sa_dim_col_B,
    input  logic                               sa_done,
    input  logic [7:0][7:0][`DATA_WIDTH-1:0]   sa_out,
    output logic                               wr_valid,
    output logic [`ADDR_WIDTH-1:0]             wr_addr,
    output logic [`DATA_WIDTH-1:0]             wr_data,
    output logic                               wr_accum,
    input  logic                               wr_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output sched_state_t                       dbg_state
);

    sched_state_t      state_q, state_next;

    logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;
    logic [DIM_W-1:0]  m_q, k_q, n_q;
    logic [DIM_W-1:0]  ti_q, tj_q, tk_q;

    logic              dims_ok;
    logic              last_i, last_j, last_k;
    logic              last_beat;
    logic [ADDR_W-1:0] c_row_base;
    logic [ADDR_W-1:0] tile_step;

    assign dims_ok = dim_ok(m_q) && dim_ok(k_q) && dim_ok(n_q);

    // Tile counts are dim/8; index i is last when i+1 reaches that count.
    assign last_i = ((ti_q + DIM_W'(1)) == (m_q >> 3));
    assign last_j = ((tj_q + DIM_W'(1)) == (n_q >> 3));
    assign last_k = ((tk_q + DIM_W'(1)) == (k_q >> 3));

    // Indices only move in ADVANCE, so these are stable from LAUNCH through
    // the whole driver run. All math wraps at ADDR_W.
    assign tile_step    = ADDR_W'(TILE);
    assign sa_base_A    = base_a_q + tile_step * ADDR_W'(ti_q) * ADDR_W'(k_q) + tile_step * ADDR_W'(tk_q);
    assign sa_base_B    = base_b_q + tile_step * ADDR_W'(tk_q) * ADDR_W'(n_q) + tile_step * ADDR_W'(tj_q);
    assign sa_dim_col_A = k_q;
    assign sa_dim_col_B = n_q;
    assign c_row_base   = base_c_q + tile_step * ADDR_W'(ti_q) * ADDR_W'(n_q) + tile_step * ADDR_W'(tj_q);

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_next = state_q;
        sa_start   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE:    if (go) state_next = CHECK;
            CHECK: begin
                if (dims_ok) begin
                    state_next = LAUNCH;
                end else begin
                    err        = 1'b1;
                    state_next = IDLE;
                end
            end
            LAUNCH: begin
                sa_start   = 1'b1;
                state_next = WAIT_SA;
            end
            WAIT_SA: if (sa_done) state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   if (last_beat) state_next = ADVANCE;
            ADVANCE: state_next = (last_i && last_j && last_k) ? FINISH : LAUNCH;
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            m_q      <= '0;
            k_q      <= '0;
            n_q      <= '0;
            ti_q     <= '0;
            tj_q     <= '0;
            tk_q     <= '0;
        end else begin
            state_q <= state_next;
            if (state_q == IDLE && go) begin
                base_a_q <= base_A;
                base_b_q <= base_B;
                base_c_q <= base_C;
                m_q      <= dim_M;
                k_q      <= dim_K;
                n_q      <= dim_N;
            end
            if (state_q == CHECK) begin
                ti_q <= '0;
                tj_q <= '0;
                tk_q <= '0;
            end
            // tk innermost, then tj, then ti; each wraps to 0 at its limit.
            if (state_q == ADVANCE) begin
                if (!last_k) begin
                    tk_q <= tk_q + DIM_W'(1);
                end else begin
                    tk_q <= '0;
                    if (!last_j) begin
                        tj_q <= tj_q + DIM_W'(1);
                    end else begin
                        tj_q <= '0;
                        ti_q <= last_i ? '0 : ti_q + DIM_W'(1);
                    end
                end
            end
        end
    end

    sa_tile_wb u_wb (
        .clock     (clock),
        .reset_n   (reset_n),
        .capture   (state_q == CAPTURE),
        .write_en  (state_q == WRITE),
        .sa_out    (sa_out),
        .row_base  (c_row_base),
        .stride    (n_q),
        .accum     (tk_q != '0),
        .wr_ready  (wr_ready),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_accum  (wr_accum),
        .last_beat (last_beat)
    );

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler. The bench plays the systolic driver
// and the write sink; every expected value comes from the job description
// and the tile pattern the bench itself drives.
module tb_sa_tile_scheduler;
  import sa_tile_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic                             go;
  logic [ADDR_W-1:0]                base_A, base_B, base_C;
  logic [DIM_W-1:0]                 dim_M, dim_K, dim_N;
  logic                             sa_start;
  logic [ADDR_W-1:0]                sa_base_A, sa_base_B;
  logic [DIM_W-1:0]                 sa_dim_col_A, sa_dim_col_B;
  logic                             sa_done;
  logic [7:0][7:0][DATA_W-1:0]      sa_out;
  logic                             wr_valid;
  logic [ADDR_W-1:0]                wr_addr;
  logic [DATA_W-1:0]                wr_data;
  logic                             wr_accum;
  logic                             wr_ready;
  logic                             busy, done, err;
  sched_state_t                     dbg_state;

  sa_tile_scheduler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .go           (go),
    .base_A       (base_A),
    .base_B       (base_B),
    .base_C       (base_C),
    .dim_M        (dim_M),
    .dim_K        (dim_K),
    .dim_N        (dim_N),
    .sa_start     (sa_start),
    .sa_base_A    (sa_base_A),
    .sa_base_B    (sa_base_B),
    .sa_dim_col_A (sa_dim_col_A),
    .sa_dim_col_B (sa_dim_col_B),
    .sa_done      (sa_done),
    .sa_out       (sa_out),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_accum     (wr_accum),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int launch_n = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int l, input int r, input int c);
    return DATA_W'(32'hA500_0000 + l * 256 + r * 8 + c);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Runs one job; stop_beat >= 0 abandons the first tile after that many beats.
  task automatic run_job(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                         input logic [ADDR_W-1:0] bc, input int m, input int k, input int n,
                         input bit toggle, input int stop_beat);
    int cnt;
    logic [ADDR_W-1:0] exp_a, exp_b, exp_addr, held_addr;
    logic [DATA_W-1:0] held_data;
    base_A = ba; base_B = bb; base_C = bc;
    dim_M = DIM_W'(m); dim_K = DIM_W'(k); dim_N = DIM_W'(n);
    go = 1'b1;
    step();
    go = 1'b0;
    check("busy_after_go", busy, 1);
    for (int ti = 0; ti < m / 8; ti++) begin
      for (int tj = 0; tj < n / 8; tj++) begin
        for (int tk = 0; tk < k / 8; tk++) begin
          cnt = 0;
          while (!sa_start && cnt < 20) begin
            step();
            cnt++;
          end
          check("sa_start", sa_start, 1);
          exp_a = ba + ADDR_W'(8 * ti * k + 8 * tk);
          exp_b = bb + ADDR_W'(8 * tk * n + 8 * tj);
          check("sa_base_A", sa_base_A, exp_a);
          check("sa_base_B", sa_base_B, exp_b);
          check("sa_dim_col_A", sa_dim_col_A, DIM_W'(k));
          check("sa_dim_col_B", sa_dim_col_B, DIM_W'(n));
          step();
          check("sa_start_width", sa_start, 0);
          check("state_wait", dbg_state, WAIT_SA);
          // A second go while busy must change nothing.
          go = 1'b1; base_A = 32'hDEAD_0000; dim_K = 16'd12;
          step();
          go = 1'b0; base_A = ba; dim_K = DIM_W'(k);
          check("base_A_hold", sa_base_A, exp_a);
          check("base_B_hold", sa_base_B, exp_b);
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              sa_out[r][c] = pat(launch_n, r, c);
          sa_done = 1'b1;
          step();
          sa_done = 1'b0;
          check("state_capture", dbg_state, CAPTURE);
          step();
          sa_out = '1;
          for (int b = 0; b < 64; b++) begin
            if (b == stop_beat) return;
            exp_addr = bc + ADDR_W'((8 * ti + b / 8) * n + 8 * tj + b % 8);
            if (toggle) begin
              wr_ready = 1'b0;
              held_addr = wr_addr;
              held_data = wr_data;
              step();
              check("stall_valid", wr_valid, 1);
              check("stall_addr", wr_addr, held_addr);
              check("stall_data", wr_data, held_data);
            end
            wr_ready = 1'b1;
            check("wr_valid", wr_valid, 1);
            check("wr_addr", wr_addr, exp_addr);
            check("wr_data", wr_data, pat(launch_n, b / 8, b % 8));
            check("wr_accum", wr_accum, (tk != 0) ? 1 : 0);
            if (ti == 1 && tj == 1 && b == 0 && bc == 32'h100)
              check("tile11_first_addr", wr_addr, 32'h188);
            step();
          end
          wr_ready = 1'b0;
          launch_n++;
          check("state_advance", dbg_state, ADVANCE);
          check("wr_valid_after", wr_valid, 0);
        end
      end
    end
    cnt = 0;
    while (!done && cnt < 10) begin
      step();
      cnt++;
    end
    check("done_pulse", done, 1);
    step();
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic run_bad_job(input int m, input int k, input int n);
    base_A = '0; base_B = '0; base_C = '0;
    dim_M = DIM_W'(m); dim_K = DIM_W'(k); dim_N = DIM_W'(n);
    go = 1'b1;
    step();
    go = 1'b0;
    check("err_pulse", err, 1);
    check("err_no_start", sa_start, 0);
    step();
    check("err_width", err, 0);
    check("err_busy", busy, 0);
    check("err_state", dbg_state, IDLE);
    check("err_no_start2", sa_start, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    go = 1'b0; sa_done = 1'b0; wr_ready = 1'b0; sa_out = '0;
    base_A = '0; base_B = '0; base_C = '0;
    dim_M = '0; dim_K = '0; dim_N = '0;
    step();
    step();
    check("rst_state", dbg_state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_sa_start", sa_start, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_sa_base_A", sa_base_A, 0);
    reset_n = 1'b1;
    step();

    // Driver completion outside WAIT_SA is ignored.
    sa_done = 1'b1;
    step();
    sa_done = 1'b0;
    check("stray_done_state", dbg_state, IDLE);
    check("stray_done_busy", busy, 0);

    // Single tile, all bases zero.
    run_job(32'h0, 32'h0, 32'h0, 8, 8, 8, 1'b0, -1);
    // 2x2 output tiles with C at 0x100.
    run_job(32'h40, 32'h2000, 32'h100, 16, 8, 16, 1'b0, -1);
    // Two K slices: second one accumulates.
    run_job(32'h0, 32'h0, 32'h0, 8, 16, 8, 1'b0, -1);
    // Sink stalls every other cycle.
    run_job(32'h10, 32'h20, 32'h300, 8, 8, 8, 1'b1, -1);
    // Illegal dimensions.
    run_bad_job(8, 12, 8);
    run_bad_job(0, 8, 8);

    // Reset in the middle of WRITE.
    run_job(32'h0, 32'h0, 32'h0, 8, 8, 8, 1'b0, 30);
    check("pre_rst_state", dbg_state, WRITE);
    reset_n = 1'b0;
    wr_ready = 1'b0;
    #2;
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_wr_accum", wr_accum, 0);
    check("mid_rst_sa_start", sa_start, 0);
    check("mid_rst_sa_base_A", sa_base_A, 0);
    check("mid_rst_sa_base_B", sa_base_B, 0);
    check("mid_rst_dim_col_A", sa_dim_col_A, 0);
    check("mid_rst_done_err", {done, err}, 0);
    step();
    reset_n = 1'b1;
    step();
    run_job(32'h8, 32'h18, 32'h500, 8, 8, 8, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
